bcd2bin_seq: RTL and testbench

Sequential BCD-to-binary converter: it turns a packed multi-digit BCD entry into a `WIDTH`-bit binary value. It is the input-side counterpart of the binary-to-BCD display converter, and sits between decimal entry (switches or keypad) and the ALU operands `a`/`b`. It uses a start/done handshake with constant latency, checks that each digit is valid, and checks that the value fits in range.

---
 rtl/bcd2bin_seq_if.sv | 28 ++
 rtl/bcd2bin_seq.sv | 161 ++++++++++++++++
 tb/tb_bcd2bin_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_if.sv
// Start/done handshake bundle for bcd2bin_seq.
// The sgn wire exists only when BCD2BIN_SIGN_EN is defined.
interface bcd2bin_seq_if #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned DIGITS = 2
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BCD2BIN_SIGN_EN
    logic                  sgn;
`endif
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  err;

`ifdef BCD2BIN_SIGN_EN
    modport master (output start, output bcd, output sgn,
                    input bin, input busy, input done, input err);
    modport slave  (input start, input bcd, input sgn,
                    output bin, output busy, output done, output err);
`else
    modport master (output start, output bcd,
                    input bin, input busy, input done, input err);
    modport slave  (input start, input bcd,
                    output bin, output busy, output done, output err);
`endif
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first, fixed latency.
// Optional feature macro: BCD2BIN_SIGN_EN (adds sgn input, two's complement result).
module bcd2bin_seq #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned DIGITS = 2
) (
    input  logic           clk,
    input  logic           rst,
    bcd2bin_seq_if.slave   bus
);
    localparam int unsigned AW = WIDTH + 4;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
    localparam logic [AW-1:0] MAX_U = {4'b0, {WIDTH{1'b1}}};
`ifdef BCD2BIN_SIGN_EN
    localparam logic [AW-1:0] POS_MAX = {5'b0, {(WIDTH-1){1'b1}}};
    localparam logic [AW-1:0] NEG_MAX = {4'b0, 1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {StIdle, StConv, StFinal} state_e;

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] sr_q, sr_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bad_q, bad_d;
    logic                ovf_q, ovf_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
`ifdef BCD2BIN_SIGN_EN
    logic                sgn_q, sgn_d;
`endif

    logic [3:0]          digit;
    logic                digit_bad;
    logic [AW-1:0]       acc_step;
    logic                step_ovf;
    logic                range_err;
    logic                res_err;
    logic [WIDTH-1:0]    res_bin;
    logic                accept;

    // Headroom of four bits keeps acc*10 + 15 from wrapping when acc <= 2^WIDTH-1.
    always_comb begin
        digit     = sr_q[4*DIGITS-1 -: 4];
        digit_bad = (digit > 4'd9);
        acc_step  = (acc_q << 3) + (acc_q << 1) + {{WIDTH{1'b0}}, digit};
        step_ovf  = (acc_step > MAX_U);
    end

`ifdef BCD2BIN_SIGN_EN
    always_comb begin
        range_err = sgn_q ? (acc_q > NEG_MAX) : (acc_q > POS_MAX);
        res_err   = bad_q | ovf_q | range_err;
        if (res_err) begin
            res_bin = '0;
        end else if (sgn_q) begin
            res_bin = -acc_q[WIDTH-1:0];
        end else begin
            res_bin = acc_q[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        range_err = 1'b0;
        res_err   = bad_q | ovf_q | range_err;
        res_bin   = res_err ? '0 : acc_q[WIDTH-1:0];
    end
`endif

    assign accept = bus.start && ((state_q == StIdle) || (state_q == StFinal));

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        ovf_d   = ovf_q;
        bin_d   = bin_q;
        err_d   = err_q;
        done_d  = 1'b0;
`ifdef BCD2BIN_SIGN_EN
        sgn_d   = sgn_q;
`endif

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StConv: begin
                acc_d = step_ovf ? MAX_U : acc_step;
                ovf_d = ovf_q | step_ovf;
                bad_d = bad_q | digit_bad;
                sr_d  = sr_q << 4;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                done_d  = 1'b1;
                bin_d   = res_bin;
                err_d   = res_err;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The finishing edge doubles as an accept edge for back-to-back conversions.
        if (accept) begin
            state_d = StConv;
            sr_d    = bus.bcd;
            acc_d   = '0;
            cnt_d   = '0;
            bad_d   = 1'b0;
            ovf_d   = 1'b0;
`ifdef BCD2BIN_SIGN_EN
            sgn_d   = bus.sgn;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            ovf_q   <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            ovf_q   <= ovf_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef BCD2BIN_SIGN_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.bin  = bin_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: latency, range/digit errors, back-to-back and mid-run reset.
// Signed cases are compiled in when BCD2BIN_SIGN_EN is defined.
module tb_bcd2bin_seq;
    logic clk = 1'b0;
    logic rst;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
`ifdef BCD2BIN_SIGN_EN
    logic sgn_drv = 1'b0;
`endif

    always #5 clk = ~clk;

    bcd2bin_seq_if #(.WIDTH(6), .DIGITS(2)) bus ();

`ifdef BCD2BIN_SIGN_EN
    assign bus.sgn = sgn_drv;
`endif

    bcd2bin_seq #(.WIDTH(6), .DIGITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse, then the full k .. k+4 timing profile.
    task automatic run(input logic [7:0] v, input logic [5:0] exp_bin, input logic exp_err,
                       input string tag);
        bus.bcd   = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.bcd   = 8'hFF;
        check({tag, " busy@k"}, 32'(bus.busy), 32'd1);
        check({tag, " done@k"}, 32'(bus.done), 32'd0);
        tick();
        check({tag, " busy@k+1"}, 32'(bus.busy), 32'd1);
        check({tag, " done@k+1"}, 32'(bus.done), 32'd0);
        tick();
        check({tag, " busy@k+2"}, 32'(bus.busy), 32'd1);
        check({tag, " done@k+2"}, 32'(bus.done), 32'd0);
        tick();
        check({tag, " done@k+3"}, 32'(bus.done), 32'd1);
        check({tag, " busy@k+3"}, 32'(bus.busy), 32'd0);
        check({tag, " bin"}, 32'(bus.bin), 32'(exp_bin));
        check({tag, " err"}, 32'(bus.err), 32'(exp_err));
        tick();
        check({tag, " done@k+4"}, 32'(bus.done), 32'd0);
        check({tag, " bin hold"}, 32'(bus.bin), 32'(exp_bin));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bcd   = 8'h00;
        tick();
        tick();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset bin", 32'(bus.bin), 32'd0);
        check("reset err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        tick();

        run(8'h42, 6'd42, 1'b0, "bcd42");
        run(8'h63, 6'd63, 1'b0, "bcd63");
        run(8'h64, 6'd0, 1'b1, "bcd64");
        run(8'h99, 6'd0, 1'b1, "bcd99");
        run(8'h00, 6'd0, 1'b0, "bcd00");
        run(8'h1A, 6'd0, 1'b1, "bcd1A");
        run(8'h05, 6'd5, 1'b0, "bcd05");
        run(8'hA0, 6'd0, 1'b1, "bcdA0");

        // start held high: accepts at k and k+3, pulses during busy are ignored
        bus.bcd   = 8'h07;
        bus.start = 1'b1;
        tick();
        check("held busy@k", 32'(bus.busy), 32'd1);
        tick();
        check("held done@k+1", 32'(bus.done), 32'd0);
        tick();
        check("held done@k+2", 32'(bus.done), 32'd0);
        tick();
        check("held done@k+3", 32'(bus.done), 32'd1);
        check("held bin@k+3", 32'(bus.bin), 32'd7);
        check("held reaccept busy@k+3", 32'(bus.busy), 32'd1);
        tick();
        check("held done@k+4", 32'(bus.done), 32'd0);
        tick();
        check("held done@k+5", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        tick();
        check("held done@k+6", 32'(bus.done), 32'd1);
        check("held bin@k+6", 32'(bus.bin), 32'd7);
        check("held busy@k+6", 32'(bus.busy), 32'd0);
        tick();
        check("held done@k+7", 32'(bus.done), 32'd0);
        check("held busy@k+7", 32'(bus.busy), 32'd0);

        // reset mid-conversion with bin=7 left from the previous result
        bus.bcd   = 8'h42;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        rst       = 1'b1;
        tick();
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst bin", 32'(bus.bin), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst no done", 32'(bus.done), 32'd0);
        end
        run(8'h42, 6'd42, 1'b0, "after rst");

        // reset mid-conversion with err=1 left from the previous result
        run(8'h1A, 6'd0, 1'b1, "err before rst");
        bus.bcd   = 8'h05;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        rst       = 1'b1;
        tick();
        check("midrst2 err", 32'(bus.err), 32'd0);
        check("midrst2 busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();
        run(8'h05, 6'd5, 1'b0, "after rst2");

`ifdef BCD2BIN_SIGN_EN
        sgn_drv = 1'b1;
        run(8'h32, 6'b100000, 1'b0, "neg32");
        sgn_drv = 1'b0;
        run(8'h32, 6'd0, 1'b1, "pos32");
        sgn_drv = 1'b0;
        run(8'h31, 6'd31, 1'b0, "pos31");
        sgn_drv = 1'b1;
        run(8'h00, 6'd0, 1'b0, "neg0");
        sgn_drv = 1'b1;
        run(8'h05, 6'b111011, 1'b0, "neg5");
        sgn_drv = 1'b1;
        run(8'h33, 6'd0, 1'b1, "neg33");
        sgn_drv = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
